// File: rtl/vec_lsu_pkg.sv
// Shared types and helpers for the strided vector load/store unit.
// Default-parameter sizes are provided for benches and integrators.
package vec_lsu_pkg;

  typedef enum logic [2:0] {
    LSU_IDLE    = 3'd0,
    LSU_LD_REQ  = 3'd1,
    LSU_LD_WAIT = 3'd2,
    LSU_ST_REQ  = 3'd3,
    LSU_DONE    = 3'd4
  } lsu_state_e;

  typedef enum logic [1:0] {
    SEW8     = 2'b00,
    SEW16    = 2'b01,
    SEW32    = 2'b10,
    SEW_RSVD = 2'b11
  } sew_e;

  localparam int DEF_XLEN     = 32;
  localparam int DEF_VLEN     = 512;
  localparam int DEF_LMUL_MAX = 8;
  localparam int DEF_MAX_VLEN = DEF_VLEN * DEF_LMUL_MAX;
  localparam int DEF_MAX_EL   = DEF_MAX_VLEN / 8;
  localparam int DEF_CNT_W    = $clog2(DEF_MAX_EL) + 1;

  // Reserved width returns 0; callers never issue memory traffic for it.
  function automatic logic [2:0] sew_bytes(input sew_e s);
    case (s)
      SEW8:    return 3'd1;
      SEW16:   return 3'd2;
      SEW32:   return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/vec_lsu_strided_if.sv
// Memory port of the vector LSU: req/gnt request channel plus rvalid read return.
interface vec_lsu_strided_if #(
  parameter int XLEN = 32
) ();

  logic              lsu2mem_req;
  logic              lsu2mem_wen;
  logic [XLEN-1:0]   lsu2mem_addr;
  logic [XLEN-1:0]   lsu2mem_wdata;
  logic [XLEN/8-1:0] lsu2mem_be;
  logic              mem2lsu_gnt;
  logic              mem2lsu_rvalid;
  logic [XLEN-1:0]   mem2lsu_data;

  modport master (
    output lsu2mem_req, lsu2mem_wen, lsu2mem_addr, lsu2mem_wdata, lsu2mem_be,
    input  mem2lsu_gnt, mem2lsu_rvalid, mem2lsu_data
  );

  modport slave (
    input  lsu2mem_req, lsu2mem_wen, lsu2mem_addr, lsu2mem_wdata, lsu2mem_be,
    output mem2lsu_gnt, mem2lsu_rvalid, mem2lsu_data
  );

endinterface

// File: rtl/vec_lsu_addr_gen.sv
// Element address and index generator: running base + i*stride sum and element counter.
module vec_lsu_addr_gen #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic             step,
  input  logic [XLEN-1:0]  base,
  input  logic [XLEN-1:0]  stride,
  input  logic [CNT_W-1:0] vl,
  output logic [XLEN-1:0]  addr,
  output logic [CNT_W-1:0] idx,
  output logic             last
);

  logic [XLEN-1:0]  stride_q;
  logic [CNT_W-1:0] vl_q;

  // Stride is two's complement, so the wrapping add covers negative strides too.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      addr     <= '0;
      stride_q <= '0;
      idx      <= '0;
      vl_q     <= '0;
    end else if (start) begin
      addr     <= base;
      stride_q <= stride;
      idx      <= '0;
      vl_q     <= vl;
    end else if (step) begin
      addr <= addr + stride_q;
      idx  <= idx + CNT_W'(1);
    end
  end

  assign last = ((idx + CNT_W'(1)) == vl_q);

endmodule

// File: rtl/vec_lsu_strided.sv
// Unit/constant-stride vector load/store unit, one element per memory transaction.
// state     | meaning
// IDLE      | waiting for ld_inst / st_inst
// LD_REQ    | load request held until gnt
// LD_WAIT   | load granted, waiting for rvalid
// ST_REQ    | store request, one beat per gnt
// DONE      | one-cycle completion / error pulse
module vec_lsu_strided
  import vec_lsu_pkg::*;
#(
  parameter  int XLEN     = 32,
  parameter  int VLEN     = 512,
  parameter  int LMUL_MAX = 8,
  localparam int MAX_VLEN = VLEN * LMUL_MAX,
  localparam int MAX_EL   = MAX_VLEN / 8,
  localparam int CNT_W    = $clog2(MAX_EL) + 1
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic [XLEN-1:0]      rs1_data,
  input  logic [XLEN-1:0]      rs2_data,
  input  logic [CNT_W-1:0]     vl,
  input  logic [1:0]           sew,
  input  logic                 stride_sel,
  input  logic                 ld_inst,
  input  logic                 st_inst,
  input  logic [MAX_VLEN-1:0]  vs3_data,
  vec_lsu_strided_if.master    mem,
  output logic [MAX_VLEN-1:0]  vd_data,
  output logic                 is_loaded,
  output logic                 is_stored,
  output logic                 lsu_busy,
  output logic                 lsu_err
);

  localparam logic [2:0] ST_IDLE    = LSU_IDLE;
  localparam logic [2:0] ST_LD_REQ  = LSU_LD_REQ;
  localparam logic [2:0] ST_LD_WAIT = LSU_LD_WAIT;
  localparam logic [2:0] ST_ST_REQ  = LSU_ST_REQ;
  localparam logic [2:0] ST_DONE    = LSU_DONE;
  localparam int         OFF_W      = $clog2(MAX_VLEN);
  localparam int         BE_W       = XLEN / 8;

  logic [2:0]          state;
  sew_e                sew_q;
  logic                op_st;
  logic                err_q;
  logic [MAX_VLEN-1:0] vs3_q;
  logic [MAX_VLEN-1:0] vd_q;

  logic                start;
  logic                step;
  logic                skip_mem;
  logic [XLEN-1:0]     start_stride;
  logic [XLEN-1:0]     cur_addr;
  logic [CNT_W-1:0]    idx;
  logic                last;
  logic [2:0]          off_sh;
  logic [OFF_W-1:0]    bit_off;
  logic [XLEN-1:0]     st_elem;
  logic [BE_W-1:0]     be_mask;
  logic                req;

  always_comb begin
    start        = (state == ST_IDLE) && (ld_inst || st_inst);
    skip_mem     = (vl == '0) || (sew == SEW_RSVD);
    start_stride = stride_sel ? XLEN'(sew_bytes(sew_e'(sew))) : rs2_data;
    step         = ((state == ST_LD_WAIT) && mem.mem2lsu_rvalid) ||
                   ((state == ST_ST_REQ)  && mem.mem2lsu_gnt);
    off_sh       = 3'd3 + {1'b0, sew_q};
    bit_off      = OFF_W'(idx) << off_sh;
  end

  vec_lsu_addr_gen #(
    .XLEN  (XLEN),
    .CNT_W (CNT_W)
  ) u_addr_gen (
    .clk    (clk),
    .n_rst  (n_rst),
    .start  (start),
    .step   (step),
    .base   (rs1_data),
    .stride (start_stride),
    .vl     (vl),
    .addr   (cur_addr),
    .idx    (idx),
    .last   (last)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= ST_IDLE;
      sew_q <= SEW8;
      op_st <= 1'b0;
      err_q <= 1'b0;
      vs3_q <= '0;
      vd_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // Load has priority when both instructions arrive together.
          if (ld_inst) begin
            op_st <= 1'b0;
            sew_q <= sew_e'(sew);
            err_q <= (sew == SEW_RSVD);
            vd_q  <= '0;
            state <= skip_mem ? ST_DONE : ST_LD_REQ;
          end else if (st_inst) begin
            op_st <= 1'b1;
            sew_q <= sew_e'(sew);
            err_q <= (sew == SEW_RSVD);
            vs3_q <= vs3_data;
            state <= skip_mem ? ST_DONE : ST_ST_REQ;
          end
        end
        ST_LD_REQ: begin
          if (mem.mem2lsu_gnt) state <= ST_LD_WAIT;
        end
        ST_LD_WAIT: begin
          if (mem.mem2lsu_rvalid) begin
            case (sew_q)
              SEW8:    vd_q[bit_off +: 8]  <= mem.mem2lsu_data[7:0];
              SEW16:   vd_q[bit_off +: 16] <= mem.mem2lsu_data[15:0];
              default: vd_q[bit_off +: 32] <= mem.mem2lsu_data[31:0];
            endcase
            state <= last ? ST_DONE : ST_LD_REQ;
          end
        end
        ST_ST_REQ: begin
          if (mem.mem2lsu_gnt && last) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    case (sew_q)
      SEW8: begin
        st_elem = XLEN'(vs3_q[bit_off +: 8]);
        be_mask = BE_W'(4'b0001);
      end
      SEW16: begin
        st_elem = XLEN'(vs3_q[bit_off +: 16]);
        be_mask = BE_W'(4'b0011);
      end
      default: begin
        st_elem = XLEN'(vs3_q[bit_off +: 32]);
        be_mask = BE_W'(4'b1111);
      end
    endcase
  end

  // Address, data and enables are driven only while a request is up.
  always_comb begin
    req               = (state == ST_LD_REQ) || (state == ST_ST_REQ);
    mem.lsu2mem_req   = req;
    mem.lsu2mem_wen   = (state == ST_ST_REQ);
    mem.lsu2mem_addr  = req ? cur_addr : '0;
    mem.lsu2mem_be    = req ? be_mask : '0;
    mem.lsu2mem_wdata = (state == ST_ST_REQ) ? st_elem : '0;
    is_loaded         = (state == ST_DONE) && !op_st && !err_q;
    is_stored         = (state == ST_DONE) &&  op_st && !err_q;
    lsu_err           = (state == ST_DONE) && err_q;
    lsu_busy          = (state != ST_IDLE);
    vd_data           = vd_q;
  end

endmodule

// File: tb/tb_vec_lsu_strided.sv
// Scoreboard bench for vec_lsu_strided: memory responder checks each granted request
// against expected transactions queued by the stimulus.
module tb_vec_lsu_strided;
  import vec_lsu_pkg::*;

  localparam int XLEN     = 32;
  localparam int MAX_VLEN = DEF_MAX_VLEN;
  localparam int CNT_W    = DEF_CNT_W;

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } exp_t;

  logic                clk = 1'b0;
  logic                n_rst;
  logic [XLEN-1:0]     rs1_data, rs2_data;
  logic [CNT_W-1:0]    vl;
  logic [1:0]          sew;
  logic                stride_sel, ld_inst, st_inst;
  logic [MAX_VLEN-1:0] vs3_data;
  logic [MAX_VLEN-1:0] vd_data;
  logic                is_loaded, is_stored, lsu_busy, lsu_err;

  vec_lsu_strided_if #(.XLEN(XLEN)) mem_bus ();

  vec_lsu_strided dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .vl         (vl),
    .sew        (sew),
    .stride_sel (stride_sel),
    .ld_inst    (ld_inst),
    .st_inst    (st_inst),
    .vs3_data   (vs3_data),
    .mem        (mem_bus),
    .vd_data    (vd_data),
    .is_loaded  (is_loaded),
    .is_stored  (is_stored),
    .lsu_busy   (lsu_busy),
    .lsu_err    (lsu_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_vd(input string tag, input logic [MAX_VLEN-1:0] exp);
    for (int c = 0; c < MAX_VLEN / 64; c++)
      chk($sformatf("%s[%0d]", tag, c), vd_data[c*64 +: 64], exp[c*64 +: 64]);
  endtask

  // Memory responder state
  exp_t        exp_q[$];
  logic [31:0] rd_q[$];
  bit          mem_auto = 1'b1;
  int          gnt_delay = 0;
  int          stall_cnt = 0;
  bit          rv_pend = 1'b0;
  logic [31:0] rv_data = '0;
  int          n_wr = 0;
  logic [31:0] hold_addr, hold_wdata;
  logic [3:0]  hold_be;
  logic        man_gnt = 1'b0, man_rvalid = 1'b0;
  logic [31:0] man_data = '0;

  initial begin
    mem_bus.mem2lsu_gnt    = 1'b0;
    mem_bus.mem2lsu_rvalid = 1'b0;
    mem_bus.mem2lsu_data   = '0;
    forever begin
      exp_t e;
      @(negedge clk);
      if (!mem_auto) begin
        mem_bus.mem2lsu_gnt    = man_gnt;
        mem_bus.mem2lsu_rvalid = man_rvalid;
        mem_bus.mem2lsu_data   = man_data;
      end else begin
        mem_bus.mem2lsu_rvalid = rv_pend;
        mem_bus.mem2lsu_data   = rv_pend ? rv_data : 32'h0;
        rv_pend                = 1'b0;
        mem_bus.mem2lsu_gnt    = 1'b0;
        if (n_rst && mem_bus.lsu2mem_req) begin
          if (stall_cnt == 0) begin
            hold_addr  = mem_bus.lsu2mem_addr;
            hold_wdata = mem_bus.lsu2mem_wdata;
            hold_be    = mem_bus.lsu2mem_be;
          end else begin
            chk("hold_addr",  mem_bus.lsu2mem_addr,  hold_addr);
            chk("hold_wdata", mem_bus.lsu2mem_wdata, hold_wdata);
            chk("hold_be",    mem_bus.lsu2mem_be,    hold_be);
          end
          if (stall_cnt < gnt_delay) begin
            stall_cnt++;
          end else begin
            stall_cnt = 0;
            mem_bus.mem2lsu_gnt = 1'b1;
            if (mem_bus.lsu2mem_wen) n_wr++;
            if (exp_q.size() == 0) begin
              chk("unexpected_req", 64'(mem_bus.lsu2mem_req), 64'd0);
            end else begin
              e = exp_q.pop_front();
              chk("req_wen",  mem_bus.lsu2mem_wen,  e.wen);
              chk("req_addr", mem_bus.lsu2mem_addr, e.addr);
              chk("req_be",   mem_bus.lsu2mem_be,   e.be);
              if (e.wen) chk("req_wdata", mem_bus.lsu2mem_wdata, e.wdata);
            end
            if (!mem_bus.lsu2mem_wen) begin
              rv_pend = 1'b1;
              rv_data = (rd_q.size() != 0) ? rd_q.pop_front() : 32'hDEAD_BEEF;
            end
          end
        end
      end
    end
  end

  task automatic push_exp(input logic wen, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be);
    exp_t e;
    e.wen = wen; e.addr = addr; e.wdata = wdata; e.be = be;
    exp_q.push_back(e);
  endtask

  task automatic run_op(input bit ld, input bit st, input bit hold_st,
                        input logic [31:0] base, input logic [31:0] stride,
                        input logic [CNT_W-1:0] vl_i, input logic [1:0] sew_i,
                        input bit unit, input logic [MAX_VLEN-1:0] vs3,
                        output int n_ld, output int n_st, output int n_err,
                        output int first_cyc);
    @(negedge clk);
    rs1_data = base; rs2_data = stride; vl = vl_i; sew = sew_i;
    stride_sel = unit; vs3_data = vs3;
    ld_inst = ld; st_inst = st | hold_st;
    n_ld = 0; n_st = 0; n_err = 0; first_cyc = -1;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 1) begin
        ld_inst = 1'b0;
        if (!hold_st) st_inst = 1'b0;
      end
      if (is_loaded) n_ld++;
      if (is_stored) n_st++;
      if (lsu_err)   n_err++;
      if (first_cyc < 0 && (is_loaded || is_stored || lsu_err)) begin
        first_cyc = cyc;
        st_inst   = 1'b0;
      end
      if (first_cyc >= 0 && cyc >= first_cyc + 2) break;
    end
    chk("done_seen", 64'(first_cyc >= 0), 64'd1);
    chk("idle_after_busy", 64'(lsu_busy), 64'd0);
    chk("idle_after_req",  64'(mem_bus.lsu2mem_req), 64'd0);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);
  endtask

  logic [MAX_VLEN-1:0] exp_vd, vs3_v;
  int n_ld, n_st, n_err, fc, wr_base;

  initial begin
    n_rst = 1'b0;
    rs1_data = '0; rs2_data = '0; vl = '0; sew = '0;
    stride_sel = 1'b0; ld_inst = 1'b0; st_inst = 1'b0; vs3_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req",    64'(mem_bus.lsu2mem_req), 64'd0);
    chk("rst_wen",    64'(mem_bus.lsu2mem_wen), 64'd0);
    chk("rst_addr",   64'(mem_bus.lsu2mem_addr), 64'd0);
    chk("rst_be",     64'(mem_bus.lsu2mem_be), 64'd0);
    chk("rst_busy",   64'(lsu_busy), 64'd0);
    chk("rst_flags",  64'({is_loaded, is_stored, lsu_err}), 64'd0);
    check_vd("rst_vd", '0);
    @(negedge clk);
    n_rst = 1'b1;

    // Unit-stride 32b load, gnt same cycle, rvalid next cycle
    for (int i = 0; i < 4; i++) begin
      push_exp(1'b0, 32'h100 + 32'(4 * i), 32'h0, 4'hF);
      rd_q.push_back(32'hA0 + 32'(i));
    end
    run_op(1, 0, 0, 32'h100, 32'h0, CNT_W'(4), 2'b10, 1, '0, n_ld, n_st, n_err, fc);
    chk("t1_latency", 64'(fc), 64'd9);
    chk("t1_loaded",  64'(n_ld), 64'd1);
    chk("t1_stored",  64'(n_st), 64'd0);
    chk("t1_err",     64'(n_err), 64'd0);
    exp_vd = '0;
    exp_vd[127:0] = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    check_vd("t1_vd", exp_vd);

    // Negative-stride 8b load; only the low byte of each return is kept
    push_exp(1'b0, 32'h40, 32'h0, 4'h1);
    push_exp(1'b0, 32'h3D, 32'h0, 4'h1);
    push_exp(1'b0, 32'h3A, 32'h0, 4'h1);
    rd_q.push_back(32'h1234_56C1);
    rd_q.push_back(32'hFFFF_FFC2);
    rd_q.push_back(32'h0000_00C3);
    run_op(1, 0, 0, 32'h40, 32'hFFFF_FFFD, CNT_W'(3), 2'b00, 0, '0, n_ld, n_st, n_err, fc);
    chk("t2_loaded", 64'(n_ld), 64'd1);
    exp_vd = '0;
    exp_vd[23:0] = 24'hC3_C2_C1;
    check_vd("t2_vd", exp_vd);

    // 16b store with 3 stall cycles per beat
    for (int i = 0; i < MAX_VLEN / 32; i++) vs3_v[i*32 +: 32] = $urandom;
    push_exp(1'b1, 32'h200, {16'h0, vs3_v[15:0]},  4'h3);
    push_exp(1'b1, 32'h202, {16'h0, vs3_v[31:16]}, 4'h3);
    gnt_delay = 3;
    run_op(0, 1, 0, 32'h200, 32'h0, CNT_W'(2), 2'b01, 1, vs3_v, n_ld, n_st, n_err, fc);
    gnt_delay = 0;
    chk("t3_stored", 64'(n_st), 64'd1);
    chk("t3_loaded", 64'(n_ld), 64'd0);
    check_vd("t3_vd_kept", exp_vd);

    // vl = 0 load: completes with no memory traffic and clears vd
    run_op(1, 0, 0, 32'h500, 32'h0, CNT_W'(0), 2'b10, 1, '0, n_ld, n_st, n_err, fc);
    chk("t4_loaded", 64'(n_ld), 64'd1);
    chk("t4_err",    64'(n_err), 64'd0);
    chk("t4_latency", 64'(fc), 64'd1);
    exp_vd = '0;
    check_vd("t4_vd", exp_vd);

    // Reserved sew store: error pulse only
    wr_base = n_wr;
    run_op(0, 1, 0, 32'h600, 32'h0, CNT_W'(2), 2'b11, 1, vs3_v, n_ld, n_st, n_err, fc);
    chk("t5_err",    64'(n_err), 64'd1);
    chk("t5_stored", 64'(n_st), 64'd0);
    chk("t5_writes", 64'(n_wr - wr_base), 64'd0);

    // ld+st together, st held while busy: only the load runs
    wr_base = n_wr;
    push_exp(1'b0, 32'h300, 32'h0, 4'h3);
    push_exp(1'b0, 32'h302, 32'h0, 4'h3);
    rd_q.push_back(32'hBEEF_1111);
    rd_q.push_back(32'h0000_2222);
    run_op(1, 1, 1, 32'h300, 32'h0, CNT_W'(2), 2'b01, 1, vs3_v, n_ld, n_st, n_err, fc);
    repeat (3) @(posedge clk);
    #1;
    chk("t6_loaded", 64'(n_ld), 64'd1);
    chk("t6_stored", 64'(n_st), 64'd0);
    chk("t6_writes", 64'(n_wr - wr_base), 64'd0);
    chk("t6_idle",   64'(lsu_busy), 64'd0);
    exp_vd = '0;
    exp_vd[31:0] = 32'h2222_1111;
    check_vd("t6_vd", exp_vd);

    // Zero stride 16b load: every element from the same address
    for (int i = 0; i < 3; i++) begin
      push_exp(1'b0, 32'h80, 32'h0, 4'h3);
      rd_q.push_back(32'hF000_0001 + 32'(i));
    end
    run_op(1, 0, 0, 32'h80, 32'h0, CNT_W'(3), 2'b01, 0, '0, n_ld, n_st, n_err, fc);
    chk("t7_latency", 64'(fc), 64'd7);
    exp_vd = '0;
    exp_vd[47:0] = 48'h0003_0002_0001;
    check_vd("t7_vd", exp_vd);

    // Reset during LD_WAIT, then a late rvalid
    mem_auto = 1'b0;
    @(negedge clk);
    rs1_data = 32'h700; vl = CNT_W'(2); sew = 2'b10; stride_sel = 1'b1; ld_inst = 1'b1;
    @(posedge clk); #1;
    ld_inst = 1'b0;
    chk("t8_req",  64'(mem_bus.lsu2mem_req), 64'd1);
    chk("t8_addr", 64'(mem_bus.lsu2mem_addr), 64'h700);
    man_gnt = 1'b1;
    @(posedge clk); #1;
    man_gnt = 1'b0;
    chk("t8_wait_req",  64'(mem_bus.lsu2mem_req), 64'd0);
    chk("t8_wait_busy", 64'(lsu_busy), 64'd1);
    @(negedge clk);
    n_rst = 1'b0;
    #1;
    chk("t8_rst_busy", 64'(lsu_busy), 64'd0);
    chk("t8_rst_req",  64'(mem_bus.lsu2mem_req), 64'd0);
    chk("t8_rst_addr", 64'(mem_bus.lsu2mem_addr), 64'd0);
    check_vd("t8_rst_vd", '0);
    @(negedge clk);
    n_rst = 1'b1;
    man_rvalid = 1'b1; man_data = 32'h5555_5555;
    @(posedge clk); #1;
    man_rvalid = 1'b0; man_data = '0;
    n_ld = 0;
    for (int i = 0; i < 4; i++) begin
      if (is_loaded || lsu_busy || mem_bus.lsu2mem_req) n_ld++;
      @(posedge clk); #1;
    end
    chk("t8_late_ignored", 64'(n_ld), 64'd0);
    check_vd("t8_late_vd", '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
